// File: rtl/clk_div_pkg.sv
// Shared types and constants for the programmable clock divider.
package clk_div_pkg;
  localparam int DIV_W_DEF = 8;
  localparam int MIN_DIV   = 2;

  typedef enum logic [1:0] {OFF, RUN, PEND} state_e;
endpackage

// File: rtl/clk_div_if.sv
// Ratio-change request channel: valid/ready handshake plus illegal-ratio flag.
interface clk_div_if #(parameter int DIV_W = 8);
  logic             req_valid;
  logic [DIV_W-1:0] req_div;
  logic             req_ready;
  logic             err_illegal;

  modport master (output req_valid, req_div, input req_ready, err_illegal);
  modport slave  (input req_valid, req_div, output req_ready, err_illegal);
endinterface

// File: rtl/clk_div_core.sv
// Period counter and 50%-duty output stage; a negedge flop stretches odd ratios
// by half a reference cycle.
module clk_div_core #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] div,
  input  logic             run,
  output logic             clk_out,
  output logic             wrap,
  output logic             tick
);
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             run_q, pos_q, pos_d, neg_q, tick_q, tick_d;

  assign wrap = run_q && (cnt_q == div - DIV_W'(1));

  // run is next-cycle running, so a fresh start lands on cnt=0 with pos already high
  always_comb begin
    cnt_d  = (run && run_q && !wrap) ? cnt_q + DIV_W'(1) : '0;
    pos_d  = run && (cnt_d < (div >> 1));
    tick_d = run && (cnt_d == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      run_q  <= 1'b0;
      pos_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      run_q  <= run;
      pos_q  <= pos_d;
      tick_q <= tick_d;
    end
  end

  always_ff @(negedge clk) begin
    if (!rst_n) neg_q <= 1'b0;
    else        neg_q <= pos_q & div[0];
  end

  assign clk_out = pos_q | neg_q;
  assign tick    = tick_q;
endmodule

// File: rtl/clk_div_ctrl.sv
// Divider controller: applies ratio changes and start/stop only at period boundaries.
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int DIV_W       = DIV_W_DEF,
  parameter int DEFAULT_DIV = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  clk_div_if.slave         req,
  output logic             busy,
  output logic [DIV_W-1:0] div_active,
  output logic             clk_out,
  output logic             tick
);
  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d, pend_q, pend_d;
  logic             err_q, err_d;
  logic             accept, legal, wrap, run;

  assign req.req_ready = (state_q != PEND);
  assign accept        = req.req_valid && req.req_ready;
  assign legal         = (req.req_div >= DIV_W'(MIN_DIV));

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    pend_d  = pend_q;
    err_d   = accept && !legal;
    unique case (state_q)
      OFF: begin
        if (accept && legal) div_d = req.req_div;
        if (en) state_d = RUN;
      end
      RUN: begin
        // stopping at this boundary: nothing is emitted, so a new ratio loads directly
        if (wrap && !en) begin
          state_d = OFF;
          if (accept && legal) div_d = req.req_div;
        end else if (accept && legal) begin
          pend_d  = req.req_div;
          state_d = PEND;
        end
      end
      PEND: begin
        if (wrap) begin
          div_d   = pend_q;
          state_d = en ? RUN : OFF;
        end
      end
      default: state_d = OFF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= OFF;
      div_q   <= DIV_W'(DEFAULT_DIV);
      pend_q  <= DIV_W'(DEFAULT_DIV);
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
    end
  end

  assign run = (state_d != OFF);

  clk_div_core #(.DIV_W(DIV_W)) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .div     (div_q),
    .run     (run),
    .clk_out (clk_out),
    .wrap    (wrap),
    .tick    (tick)
  );

  assign busy            = (state_q == PEND);
  assign div_active      = div_q;
  assign req.err_illegal = err_q;
endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench: expected (period, high) pairs queued per output period and
// checked as clk_out edges arrive; tick checked against observed rises.
module tb_clk_div_ctrl;
  logic       clk = 1'b0;
  logic       rst_n, en;
  logic       busy, clk_out, tick;
  logic [7:0] div_active;

  clk_div_if #(.DIV_W(8)) req_if ();

  clk_div_ctrl #(.DIV_W(8), .DEFAULT_DIV(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .req        (req_if.slave),
    .busy       (busy),
    .div_active (div_active),
    .clk_out    (clk_out),
    .tick       (tick)
  );

  always #5 clk = ~clk;

  typedef struct { longint per; longint hi; } exp_t;
  exp_t   sb[$];
  int     checks = 0;
  int     failures = 0;
  bit     mon_en = 0;
  bit     mon_pend = 0;
  longint pend_per = 0;
  longint last_rise = 0;
  logic   co_pre = 1'b0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input longint per, input longint hi, input int n);
    for (int i = 0; i < n; i++) sb.push_back('{per: per, hi: hi});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rise(input string tag);
    int n = 0;
    do begin
      step();
      n++;
    end while (!tick && n < 200);
    chk(tag, tick, 1);
  endtask

  // period measured rise-to-rise, high measured rise-to-fall
  always @(posedge clk_out) if (mon_en) begin
    if (mon_pend) chk("period", $time - last_rise, pend_per);
    mon_pend  = 0;
    last_rise = $time;
  end

  always @(negedge clk_out) if (mon_en) begin
    exp_t e;
    if (sb.size() == 0) chk("sb_underflow", sb.size(), 1);
    else begin
      e = sb.pop_front();
      chk("high", $time - last_rise, e.hi);
      pend_per = e.per;
      mon_pend = 1;
    end
  end

  always @(negedge clk) begin
    #4;
    co_pre = clk_out;
  end

  always @(posedge clk) begin
    #1;
    if (mon_en) chk("tick_align", tick, (!co_pre && clk_out));
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; en = 1'b0;
    req_if.req_valid = 1'b0; req_if.req_div = '0;
    repeat (3) step();
    chk("rst_div",   div_active, 3);
    chk("rst_clk",   clk_out, 0);
    chk("rst_tick",  tick, 0);
    chk("rst_err",   req_if.err_illegal, 0);
    chk("rst_busy",  busy, 0);
    chk("rst_ready", req_if.req_ready, 1);
    rst_n = 1'b1; mon_en = 1;

    // 1: default ratio 3
    push_exp(30, 15, 3);
    en = 1'b1;
    step();
    chk("t1_first_tick", tick, 1);
    chk("t1_first_clk", clk_out, 1);
    wait_rise("t1_rise2");
    wait_rise("t1_rise3");

    // 2: ratio 4 requested mid-period
    push_exp(40, 20, 3);
    step();
    req_if.req_valid = 1'b1; req_if.req_div = 8'd4;
    step();
    req_if.req_valid = 1'b0;
    chk("t2_busy", busy, 1);
    chk("t2_ready", req_if.req_ready, 0);
    chk("t2_div_old", div_active, 3);
    step();
    chk("t2_busy_clr", busy, 0);
    chk("t2_div_new", div_active, 4);
    chk("t2_ready_back", req_if.req_ready, 1);
    chk("t2_tick", tick, 1);

    // 3: ratio 5 accepted on the wrap edge -> one more period at 4
    wait_rise("t3_rise");
    push_exp(50, 25, 1);
    repeat (3) step();
    req_if.req_valid = 1'b1; req_if.req_div = 8'd5;
    step();
    req_if.req_valid = 1'b0;
    chk("t3_busy", busy, 1);
    chk("t3_div_old", div_active, 4);
    chk("t3_tick", tick, 1);
    wait_rise("t3_rise_new");
    chk("t3_div_new", div_active, 5);
    chk("t3_busy_clr", busy, 0);

    // 4: illegal ratio 1
    step();
    req_if.req_valid = 1'b1; req_if.req_div = 8'd1;
    step();
    req_if.req_valid = 1'b0;
    chk("t4_err", req_if.err_illegal, 1);
    chk("t4_div", div_active, 5);
    chk("t4_busy", busy, 0);
    step();
    chk("t4_err_pulse", req_if.err_illegal, 0);

    // 5: move to 7, stop mid-period, reload 6 while off, restart
    req_if.req_valid = 1'b1; req_if.req_div = 8'd7;
    step();
    req_if.req_valid = 1'b0;
    chk("t5_busy", busy, 1);
    push_exp(70, 35, 1);
    wait_rise("t5_rise7");
    chk("t5_div7", div_active, 7);
    repeat (2) step();
    en = 1'b0;
    repeat (5) step();
    chk("t5_off_clk", clk_out, 0);
    chk("t5_off_busy", busy, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t5_off_low", clk_out, 0);
    end
    mon_pend = 0;
    req_if.req_valid = 1'b1; req_if.req_div = 8'd6;
    step();
    req_if.req_valid = 1'b0;
    chk("t5_load_off", div_active, 6);
    chk("t5_busy_off", busy, 0);
    push_exp(60, 30, 2);
    en = 1'b1;
    step();
    chk("t5_restart_tick", tick, 1);
    chk("t5_restart_clk", clk_out, 1);
    wait_rise("t5_rise6");

    // 6: reset while a change is pending
    step();
    req_if.req_valid = 1'b1; req_if.req_div = 8'd9;
    step();
    req_if.req_valid = 1'b0;
    chk("t6_busy", busy, 1);
    chk("t6_ready", req_if.req_ready, 0);
    rst_n = 1'b0;
    step();
    chk("t6_div", div_active, 3);
    chk("t6_busy_clr", busy, 0);
    chk("t6_ready", req_if.req_ready, 1);
    chk("t6_clk", clk_out, 0);
    step();
    mon_pend = 0;
    push_exp(30, 15, 2);
    rst_n = 1'b1;
    step();
    chk("t6_restart_tick", tick, 1);
    wait_rise("t6_rise2");
    en = 1'b0;
    repeat (5) step();
    mon_pend = 0;
    chk("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
